// File: rtl/adc_bcd_converter.sv
// adc_bcd_converter: averages blocks of 2^AVG_LOG2 unsigned 12-bit ADC
// samples and converts each average to four BCD digits with a
// shift-and-add-3 (double dabble) engine, one bit per clock.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_data, i_valid 12-bit sample and its one-cycle strobe
//   o_ones..o_thousands  BCD digits of the last converted average (held)
//   o_valid         one-cycle pulse, digits updated this cycle
//   o_busy          high while a conversion is running (CONV or DONE)
//   o_drop          one-cycle pulse, a finished average was discarded
module adc_bcd_converter #(
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] i_data,
  input  logic        i_valid,
  output logic [3:0]  o_ones,
  output logic [3:0]  o_tens,
  output logic [3:0]  o_hundreds,
  output logic [3:0]  o_thousands,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_drop
);

  localparam int unsigned DW    = 12;
  localparam int unsigned AW    = DW + AVG_LOG2;
  localparam int unsigned CW    = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int unsigned NS    = 1 << AVG_LOG2;
  localparam int unsigned BW    = 16;
  localparam int unsigned IW    = 4;
  localparam int unsigned ITERS = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   bin_q, bin_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic [BW-1:0]   digits_q, digits_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            drop_q, drop_d;

  logic [AW-1:0]      sum_c;
  logic               last_c;
  logic [DW-1:0]      avg_c;
  logic [BW+DW-1:0]   shift_c;

  // Add 3 to every nibble that is 5 or more, ahead of the left shift.
  function automatic logic [BW-1:0] bcd_adjust(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Block accumulation: the sum includes the current sample so the average
  // is ready on the edge that accepts the last sample of a block.
  assign sum_c  = acc_q + AW'(i_data);
  assign last_c = i_valid && (cnt_q == CW'(NS - 1));
  assign avg_c  = DW'(sum_c >> AVG_LOG2);

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    iter_d   = iter_q;
    digits_d = digits_q;
    valid_d  = 1'b0;
    drop_d   = 1'b0;
    shift_c  = '0;

    // Samples are accepted in every state.
    if (i_valid) begin
      if (last_c) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum_c;
        cnt_d = cnt_q + CW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (last_c) begin
          bin_d   = avg_c;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        shift_c = {bcd_adjust(bcd_q), bin_q} << 1;
        bcd_d   = shift_c[BW+DW-1:DW];
        bin_d   = shift_c[DW-1:0];
        iter_d  = iter_q + IW'(1);
        if (iter_q == IW'(ITERS - 1)) state_d = DONE;
        drop_d  = last_c;
      end
      DONE: begin
        digits_d = bcd_q;
        valid_d  = 1'b1;
        state_d  = IDLE;
        // DONE is still the sampled state here, so a new average is lost.
        drop_d   = last_c;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      digits_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      iter_q   <= iter_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
    end
  end

  assign o_thousands = digits_q[15:12];
  assign o_hundreds  = digits_q[11:8];
  assign o_tens      = digits_q[7:4];
  assign o_ones      = digits_q[3:0];
  assign o_valid     = valid_q;
  assign o_busy      = busy_q;
  assign o_drop      = drop_q;

endmodule

// File: tb/tb_adc_bcd_converter.sv
// Directed testbench: three instances (AVG_LOG2 = 0, 2, 4) share clock and
// reset; each gets its own sample stream. Digits compared as 16-bit BCD.
module tb_adc_bcd_converter;

  logic clk;
  logic rst_n;

  logic [11:0] data [3];
  logic        vld  [3];
  logic [3:0]  ones [3];
  logic [3:0]  tens [3];
  logic [3:0]  huns [3];
  logic [3:0]  thos [3];
  logic        ovld [3];
  logic        busy [3];
  logic        drop [3];

  int vcnt [3];
  int bcnt [3];
  int dcnt [3];

  int errors = 0;
  int checks = 0;

  adc_bcd_converter #(.AVG_LOG2(0)) u_avg1 (
    .clk(clk), .rst_n(rst_n), .i_data(data[0]), .i_valid(vld[0]),
    .o_ones(ones[0]), .o_tens(tens[0]), .o_hundreds(huns[0]),
    .o_thousands(thos[0]), .o_valid(ovld[0]), .o_busy(busy[0]),
    .o_drop(drop[0]));

  adc_bcd_converter #(.AVG_LOG2(2)) u_avg4 (
    .clk(clk), .rst_n(rst_n), .i_data(data[1]), .i_valid(vld[1]),
    .o_ones(ones[1]), .o_tens(tens[1]), .o_hundreds(huns[1]),
    .o_thousands(thos[1]), .o_valid(ovld[1]), .o_busy(busy[1]),
    .o_drop(drop[1]));

  adc_bcd_converter #(.AVG_LOG2(4)) u_avg16 (
    .clk(clk), .rst_n(rst_n), .i_data(data[2]), .i_valid(vld[2]),
    .o_ones(ones[2]), .o_tens(tens[2]), .o_hundreds(huns[2]),
    .o_thousands(thos[2]), .o_valid(ovld[2]), .o_busy(busy[2]),
    .o_drop(drop[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int digits(input int d);
    return {16'd0, thos[d], huns[d], tens[d], ones[d]};
  endfunction

  // Advance to the next falling edge and tally pulses of every instance.
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (ovld[d] === 1'b1) vcnt[d]++;
      if (busy[d] === 1'b1) bcnt[d]++;
      if (drop[d] === 1'b1) dcnt[d]++;
    end
  endtask

  // Called at a falling edge; sample is taken on the following rising edge.
  task automatic send(input int d, input logic [11:0] v);
    data[d] = v;
    vld[d]  = 1'b1;
    tick();
    vld[d]  = 1'b0;
  endtask

  // Cycles from the accepting edge of the last sent sample to o_valid.
  task automatic wait_valid(input int d, output int lat);
    int v0;
    v0  = vcnt[d];
    lat = 0;
    while (vcnt[d] == v0 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int b0;
    int d0;
    int v0;

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      data[d] = '0;
      vld[d]  = 1'b0;
      vcnt[d] = 0;
      bcnt[d] = 0;
      dcnt[d] = 0;
    end
    tick();
    tick();

    // Reset state of every instance.
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_digits%0d", d), digits(d), 0);
      check($sformatf("rst_flags%0d", d), {ovld[d], busy[d], drop[d]}, 0);
    end
    rst_n = 1'b1;
    tick();

    // Four-sample average 4006/4 truncates to 1001.
    send(1, 12'd1000);
    send(1, 12'd1001);
    send(1, 12'd1002);
    b0 = bcnt[1];
    send(1, 12'd1003);
    wait_valid(1, lat);
    check("avg4_latency", lat, 13);
    check("avg4_digits", digits(1), 'h1001);
    check("avg4_busy_cycles", bcnt[1] - b0, 13);

    // Single-sample full scale, then zero.
    b0 = bcnt[0];
    send(0, 12'd4095);
    wait_valid(0, lat);
    check("max_latency", lat, 13);
    check("max_digits", digits(0), 'h4095);
    check("max_busy_cycles", bcnt[0] - b0, 13);
    tick();
    b0 = bcnt[0];
    send(0, 12'd0);
    wait_valid(0, lat);
    check("zero_digits", digits(0), 'h0000);
    check("zero_busy_cycles", bcnt[0] - b0, 13);
    tick();

    // Second average arrives mid-conversion and is dropped.
    d0 = dcnt[0];
    v0 = vcnt[0];
    send(0, 12'h123);
    tick();
    send(0, 12'h456);
    wait_valid(0, lat);
    check("drop_first_digits", digits(0), 'h0291);
    check("drop_pulses", dcnt[0] - d0, 1);
    repeat (20) tick();
    check("drop_hold_digits", digits(0), 'h0291);
    check("drop_single_valid", vcnt[0] - v0, 1);

    // Average completing on the DONE->IDLE edge is dropped too.
    d0 = dcnt[0];
    v0 = vcnt[0];
    send(0, 12'd255);
    repeat (12) tick();
    send(0, 12'd999);
    check("edge_drop_valid_now", int'(ovld[0]), 1);
    repeat (20) tick();
    check("edge_drop_pulses", dcnt[0] - d0, 1);
    check("edge_drop_valids", vcnt[0] - v0, 1);
    check("edge_drop_digits", digits(0), 'h0255);

    // Sixteen full-scale samples must not overflow.
    for (int i = 0; i < 15; i++) send(2, 12'd4095);
    send(2, 12'd4095);
    wait_valid(2, lat);
    check("avg16_latency", lat, 13);
    check("avg16_max_digits", digits(2), 'h4095);
    tick();
    // 7,8 alternating: 120/16 = 7.5 truncates to 7.
    for (int i = 0; i < 7; i++) begin
      send(2, 12'd7);
      send(2, 12'd8);
    end
    send(2, 12'd7);
    send(2, 12'd8);
    wait_valid(2, lat);
    check("avg16_trunc_digits", digits(2), 'h0007);
    tick();

    // Reset during a conversion with a partial block pending.
    for (int i = 0; i < 4; i++) send(1, 12'd500);
    for (int i = 0; i < 3; i++) send(1, 12'd3000);
    check("pre_rst_busy", int'(busy[1]), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", int'(busy[1]), 0);
    check("async_rst_digits", digits(1), 0);
    tick();
    rst_n = 1'b1;
    v0 = vcnt[1];
    repeat (20) tick();
    check("no_valid_after_rst", vcnt[1] - v0, 0);
    for (int i = 0; i < 3; i++) send(1, 12'd2000);
    send(1, 12'd2000);
    wait_valid(1, lat);
    check("post_rst_latency", lat, 13);
    repeat (20) tick();
    check("post_rst_valids", vcnt[1] - v0, 1);
    check("post_rst_digits", digits(1), 'h2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_bcd_converter.md
ADC_BCD_CONVERTER -- requirements
Module: adc_bcd_converter

Interface
REQ-001 Parameter AVG_LOG2, default 2: log2 of the number of 12-bit samples averaged per displayed value; legal range 0..4.
REQ-002 clk  input  1  system clock; the only clock in the block; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 i_data  input  12  unsigned ADC sample from the SPI reader stage.
REQ-005 i_valid  input  1  one-cycle strobe; i_data is valid in this cycle.
REQ-006 o_ones, o_tens, o_hundreds, o_thousands  output  4 each  BCD digits of the last converted average, fed to the 7-segment controller.
REQ-007 o_valid  output  1  one-cycle pulse; digit outputs updated this cycle.
REQ-008 o_busy  output  1  high while a BCD conversion is in progress.
REQ-009 o_drop  output  1  one-cycle pulse; a completed average was discarded because the converter was busy.

Function
REQ-010 Accumulator SHALL be 12+AVG_LOG2 bits wide and SHALL never overflow; sample counter SHALL be AVG_LOG2 bits wide (1 bit when AVG_LOG2=0, unused).
REQ-011 Each cycle with i_valid=1 SHALL accept i_data into the accumulator, regardless of converter state.
REQ-012 On acceptance of sample number 2^AVG_LOG2 of a block: average = (accumulator + i_data) >> AVG_LOG2, truncated, 12 bits; accumulator and counter SHALL clear at that same edge.
REQ-013 FSM states: IDLE, CONV, DONE.
REQ-014 IDLE: when an average completes (edge N), load it into the 12-bit binary shift register, clear the 16-bit BCD register, iteration count = 0, go to CONV.
REQ-015 CONV: each cycle, add 3 to every BCD nibble >= 5, then shift {BCD, binary} left by one; after exactly 12 iterations (edges N+1..N+12) go to DONE.
REQ-016 DONE: at edge N+13 register the four BCD nibbles onto the digit outputs, set o_valid=1 for that single cycle, return to IDLE.
REQ-017 Latency SHALL be exactly 13 clk cycles from the accepting edge of the last sample to the o_valid cycle.
REQ-018 o_busy SHALL be 1 in CONV and DONE, 0 in IDLE.
REQ-019 An average completing while state is CONV or DONE SHALL be discarded (no queueing) and o_drop SHALL pulse for one cycle; the running conversion SHALL be unaffected.
REQ-020 An average completing on the same edge the FSM returns DONE->IDLE SHALL be discarded with o_drop (FSM is not IDLE when sampled).
REQ-021 Digit outputs SHALL hold their value between o_valid pulses.
REQ-022 Each digit output SHALL always be in 0..9; input 4095 SHALL yield 4,0,9,5.

Reset
REQ-023 rst_n low SHALL immediately force: FSM=IDLE, accumulator=0, counter=0, all digit outputs=0, o_valid=0, o_busy=0, o_drop=0.
REQ-024 Reset asserted mid-conversion or mid-block SHALL abandon the conversion and partial accumulation; no o_valid after release until a full new block is accepted.
REQ-025 After rst_n rises, the first i_valid SHALL be counted as sample 1 of a new block.

Verification
REQ-026 AVG_LOG2=2; samples 1000,1001,1002,1003 -> after 13 cycles o_valid pulse, digits 1,0,0,1 (thousands..ones).
REQ-027 AVG_LOG2=0; single sample 4095 -> digits 4,0,9,5; sample 0 -> digits 0,0,0,0; o_busy high exactly 13 cycles each.
REQ-028 AVG_LOG2=0; samples 0x123 then 0x456 two cycles apart -> first converts to 0,2,9,1; second discarded with o_drop pulse; digits stay 0,2,9,1.
REQ-029 AVG_LOG2=2; 3 samples, assert rst_n low during CONV of a prior block, release, 4 samples of 2000 -> only one o_valid, digits 2,0,0,0.
REQ-030 AVG_LOG2=4; 16 samples of 4095 -> no overflow, digits 4,0,9,5; samples 7,8 alternating x8 -> truncated average 7, digits 0,0,0,7.
